// File: rtl/rl_fifo_pkg.sv
// Shared helpers for the rl_fifo family (rl_scfifo and its reader).
package rl_fifo_pkg;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit is_power_of_2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Number of stream beats carried by one FIFO word (0 flags a bad width pair).
  function automatic int calc_ratio(input int data_size, input int out_size);
    if (out_size <= 0) return 0;
    return data_size / out_size;
  endfunction

  // Beat counter width: clog2 of the ratio, never narrower than one bit.
  function automatic int calc_beat_w(input int ratio);
    return max($clog2(ratio), 1);
  endfunction

endpackage

// File: rtl/rl_fifo_reader_if.sv
// FIFO read port plus the outgoing valid/ready beat stream of rl_fifo_reader.
// master = the reader block, slave = the FIFO/consumer side.
interface rl_fifo_reader_if #(
  parameter int DATA_SIZE = 32,
  parameter int OUT_SIZE  = 32
);
  logic                 empty_i;
  logic [DATA_SIZE-1:0] q_i;
  logic                 rdena_o;
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic [OUT_SIZE-1:0]  m_data_o;
  logic                 m_last_o;

  modport master (
    input  empty_i, q_i, m_ready_i,
    output rdena_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    output empty_i, q_i, m_ready_i,
    input  rdena_o, m_valid_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/rl_fifo_reader_buf.sv
// Two-entry word queue that soaks up the FIFO read latency.
// Push and pop on the same edge keep the count and the ordering intact.
module rl_fifo_reader_buf
  import rl_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr;

  // Next pointer/count/storage; at count 2 a push lands in the slot being popped.
  always_comb begin
    wr_ptr   = rd_ptr_q ^ count_q[0];
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) mem_d[wr_ptr] = din_i;
    if (clr_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end else begin
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01: begin
          count_d  = count_q - 2'd1;
          rd_ptr_d = ~rd_ptr_q;
        end
        2'b11:   rd_ptr_d = ~rd_ptr_q;
        default: ;
      endcase
    end
  end

  // Occupancy and head pointer; entries themselves are never cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Word storage, no reset needed since count gates its visibility.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rl_fifo_reader.sv
// Drains an rl_scfifo: issues rdena, buffers returning words and unpacks
// each word into RATIO beats on a valid/ready stream at one beat per cycle.
module rl_fifo_reader
  import rl_fifo_pkg::*;
#(
  parameter int    DATA_SIZE    = 32,
  parameter int    OUT_SIZE     = 32,
  parameter int    FIFO_LATENCY = 1,
  parameter string LSB_FIRST    = "YES"
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  rl_fifo_reader_if.master bus
);

  localparam int RATIO  = calc_ratio(DATA_SIZE, OUT_SIZE);
  localparam int BEAT_W = calc_beat_w(RATIO);
  localparam int NSLOT  = 2 ** BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  genvar gi;

  if (OUT_SIZE < 1 || (DATA_SIZE % OUT_SIZE) != 0 || !is_power_of_2(RATIO)) begin : g_bad_ratio
    $error("rl_fifo_reader: DATA_SIZE/OUT_SIZE must be an exact power of 2");
  end
  if (FIFO_LATENCY != 0 && FIFO_LATENCY != 1) begin : g_bad_latency
    $error("rl_fifo_reader: FIFO_LATENCY must be 0 or 1");
  end
  if (LSB_FIRST != "YES" && LSB_FIRST != "NO") begin : g_bad_order
    $error("rl_fifo_reader: LSB_FIRST must be \"YES\" or \"NO\"");
  end

  logic [1:0]           count;
  logic [DATA_SIZE-1:0] head;
  logic                 inflight_q, inflight_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 m_valid;
  logic                 beat_pop;
  logic                 word_pop;
  logic                 rdena;
  logic                 push;
  logic [2:0]           occupancy;
  logic [OUT_SIZE-1:0]  slice [NSLOT];

  rl_fifo_reader_buf #(
    .WIDTH (DATA_SIZE)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .push_i  (push),
    .pop_i   (word_pop),
    .din_i   (bus.q_i),
    .head_o  (head),
    .count_o (count)
  );

  // Issue/capture decisions; the ready->rdena path is combinational so a
  // word slot freed this cycle can be refilled immediately.
  always_comb begin
    m_valid    = (count != 2'd0);
    beat_pop   = m_valid & bus.m_ready_i;
    word_pop   = beat_pop & (beat_q == LAST_BEAT);
    occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, word_pop};
    rdena      = rst_ni & ~clr_i & ~bus.empty_i & (occupancy < 3'd2);
    inflight_d = (FIFO_LATENCY == 1) ? rdena : 1'b0;
    push       = (FIFO_LATENCY == 0) ? rdena : (inflight_q & ~clr_i);
  end

  // Beat counter: wraps at the last beat of a word, flush returns it to 0.
  always_comb begin
    beat_d = beat_q;
    if (clr_i)         beat_d = '0;
    else if (word_pop) beat_d = '0;
    else if (beat_pop) beat_d = beat_q + 1'b1;
  end

  // State registers for in-flight tracking and beat position.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

  // Slice table indexed by beat number; order decides which end goes first.
  for (gi = 0; gi < NSLOT; gi++) begin : g_slice
    if (gi < RATIO) begin : g_live
      localparam int SEL = (LSB_FIRST == "YES") ? gi : (RATIO - 1 - gi);
      assign slice[gi] = head[SEL*OUT_SIZE +: OUT_SIZE];
    end else begin : g_pad
      assign slice[gi] = '0;
    end
  end

  assign bus.rdena_o   = rdena;
  assign bus.m_valid_o = m_valid;
  assign bus.m_data_o  = slice[beat_q];
  assign bus.m_last_o  = m_valid & (beat_q == LAST_BEAT);

endmodule

// File: tb/tb_rl_fifo_reader.sv
// Bench for rl_fifo_reader: three configurations share one stimulus stream,
// each with its own queue-based FIFO model and expected-beat scoreboard.
//   d0: 32->32, latency 1      d1: 32->8, latency 1, LSB first
//   d2: 32->8, latency 0, MSB first
module tb_rl_fifo_reader;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        clr_i   = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] push_words [8];
  int          push_n  = 0;

  logic [2:0]       mon_valid, mon_last, mon_rdena, mon_empty, mon_idle;
  logic [2:0][31:0] mon_data;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    localparam int    OS  = (gi == 0) ? 32 : 8;
    localparam int    LAT = (gi == 2) ? 0 : 1;
    localparam string LSB = (gi == 2) ? "NO" : "YES";
    localparam int    R   = 32 / OS;

    rl_fifo_reader_if #(.DATA_SIZE(32), .OUT_SIZE(OS)) bus ();

    rl_fifo_reader #(
      .DATA_SIZE    (32),
      .OUT_SIZE     (OS),
      .FIFO_LATENCY (LAT),
      .LSB_FIRST    (LSB)
    ) u_dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .bus    (bus)
    );

    logic [31:0] fifo_q [$];
    logic [32:0] exp_q  [$];
    logic        fifo_empty_q = 1'b1;
    logic [31:0] q_q = 32'd0;
    logic        idle_b = 1'b0;

    assign bus.empty_i   = fifo_empty_q;
    assign bus.q_i       = q_q;
    assign bus.m_ready_i = m_ready;
    assign mon_valid[gi] = bus.m_valid_o;
    assign mon_last[gi]  = bus.m_last_o;
    assign mon_rdena[gi] = bus.rdena_o;
    assign mon_empty[gi] = bus.empty_i;
    assign mon_data[gi]  = 32'(bus.m_data_o);
    assign mon_idle[gi]  = idle_b;

    // FIFO model plus expected-beat generation from each word leaving the FIFO.
    logic [31:0] word;
    logic        popped;
    int          idx;
    logic [63:0] sl;
    always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        exp_q.delete();
      end else begin
        popped = 1'b0;
        if (bus.rdena_o && fifo_q.size() > 0) begin
          word   = fifo_q.pop_front();
          popped = 1'b1;
        end
        if (clr_i) exp_q.delete();
        if (popped) begin
          for (int k = 0; k < R; k++) begin
            idx = (LSB == "YES") ? k : (R - 1 - k);
            sl  = ({32'd0, word} >> (idx * OS)) & ((64'd1 << OS) - 64'd1);
            exp_q.push_back({(k == R - 1), sl[31:0]});
          end
        end
        for (int i = 0; i < push_n; i++) fifo_q.push_back(push_words[i]);
        fifo_empty_q <= (fifo_q.size() == 0);
        if (LAT == 0) q_q <= (fifo_q.size() > 0) ? fifo_q[0] : $urandom();
        else          q_q <= popped ? word : $urandom();
      end
    end

    // Scoreboard and stall/overflow/empty-read checks, sampled mid-cycle.
    logic        pv = 1'b0, pr = 1'b0, pc = 1'b0, pl = 1'b0;
    logic [31:0] pd = 32'd0;
    logic [32:0] e;
    always @(negedge clk_i) begin
      #1;
      chk($sformatf("d%0d_rd_while_empty", gi), 32'(bus.rdena_o & bus.empty_i), 32'd0);
      chk($sformatf("d%0d_count_le2", gi), 32'(u_dut.u_buf.count_o > 2'd2), 32'd0);
      if (!rst_ni) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && !pc) begin
          chk($sformatf("d%0d_stall_valid", gi), 32'(bus.m_valid_o), 32'd1);
          chk($sformatf("d%0d_stall_data", gi), mon_data[gi], pd);
          chk($sformatf("d%0d_stall_last", gi), 32'(bus.m_last_o), 32'(pl));
        end
        if (bus.m_valid_o && m_ready) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("d%0d_unexpected_beat", gi), 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            $display("[%0t] d%0d beat data=%h last=%0b exp=%h/%0b",
                     $time, gi, mon_data[gi], bus.m_last_o, e[31:0], e[32]);
            chk($sformatf("d%0d_beat_data", gi), mon_data[gi], e[31:0]);
            chk($sformatf("d%0d_beat_last", gi), 32'(bus.m_last_o), 32'(e[32]));
          end
        end
        pv = bus.m_valid_o;
        pr = m_ready;
        pc = clr_i;
        pd = mon_data[gi];
        pl = bus.m_last_o;
      end
      idle_b = (fifo_q.size() == 0) && (exp_q.size() == 0) && !bus.m_valid_o;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (mon_idle != 3'b111 && n < budget) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("drained", 32'(mon_idle), 32'd7);
  endtask

  logic [7:0] lsb_tab [4];
  logic [7:0] msb_tab [4];

  initial begin
    lsb_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
    msb_tab = '{8'h44, 8'h33, 8'h22, 8'h11};

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_valid", 32'(mon_valid), 32'd0);
    chk("rst_last", 32'(mon_last), 32'd0);
    chk("rst_rdena", 32'(mon_rdena), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Back-to-back drain of 8 preloaded words
    @(negedge clk_i);
    for (int i = 0; i < 8; i++) push_words[i] = 32'(i);
    push_n  = 8;
    m_ready = 1'b1;
    @(negedge clk_i);
    push_n = 0;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      #1;
      if (cyc == 0) chk("drain_empty_fell", 32'(mon_empty[0]), 32'd0);
      chk($sformatf("drain_rdena_c%0d", cyc), 32'(mon_rdena[0]), 32'(cyc < 8));
      chk($sformatf("drain_valid_c%0d", cyc), 32'(mon_valid[0]), 32'(cyc >= 2 && cyc <= 9));
      if (cyc >= 2 && cyc <= 9)
        chk($sformatf("drain_data_c%0d", cyc), mon_data[0], 32'(cyc - 2));
      @(negedge clk_i);
    end
    wait_idle(200);

    // Unpack one word in both orders, both latencies
    @(negedge clk_i);
    push_words[0] = 32'h44332211;
    push_n = 1;
    @(negedge clk_i);
    push_n = 0;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      #1;
      chk($sformatf("unpack_lsb_valid_c%0d", cyc), 32'(mon_valid[1]), 32'(cyc >= 2 && cyc <= 5));
      chk($sformatf("unpack_lsb_last_c%0d", cyc), 32'(mon_last[1]), 32'(cyc == 5));
      if (cyc >= 2 && cyc <= 5)
        chk($sformatf("unpack_lsb_data_c%0d", cyc), mon_data[1], 32'(lsb_tab[cyc-2]));
      chk($sformatf("unpack_msb_valid_c%0d", cyc), 32'(mon_valid[2]), 32'(cyc >= 1 && cyc <= 4));
      chk($sformatf("unpack_msb_last_c%0d", cyc), 32'(mon_last[2]), 32'(cyc == 4));
      if (cyc >= 1 && cyc <= 4)
        chk($sformatf("unpack_msb_data_c%0d", cyc), mon_data[2], 32'(msb_tab[cyc-1]));
      @(negedge clk_i);
    end
    wait_idle(200);

    // Backpressure: hold ready low for 5 cycles on beat 1 of a word
    @(negedge clk_i);
    push_words[0] = 32'hA1B2C3D4;
    push_n = 1;
    @(negedge clk_i);
    push_n = 0;
    repeat (3) @(negedge clk_i);
    m_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_hold_valid", 32'(mon_valid[1]), 32'd1);
      chk("stall_hold_data", mon_data[1], 32'hC3);
      @(negedge clk_i);
    end
    m_ready = 1'b1;
    wait_idle(200);

    // Flush with one word buffered and one in flight
    @(negedge clk_i);
    m_ready       = 1'b0;
    push_words[0] = 32'h0A0B0C0D;
    push_words[1] = 32'h1A1B1C1D;
    push_words[2] = 32'h2A2B2C2D;
    push_n        = 3;
    @(negedge clk_i);
    push_n = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    clr_i = 1'b1;
    #1;
    chk("flush_pre_valid", 32'(mon_valid[0]), 32'd1);
    chk("flush_pre_count", 32'(g_dut[0].u_dut.u_buf.count_o), 32'd1);
    @(negedge clk_i);
    clr_i   = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("flush_valid", 32'(mon_valid), 32'd0);
    chk("flush_last", 32'(mon_last), 32'd0);
    for (int n = 0; n < 20 && !mon_valid[0]; n++) begin
      @(negedge clk_i);
      #1;
    end
    chk("flush_next_word", mon_data[0], 32'h2A2B2C2D);
    wait_idle(200);

    // Asynchronous reset in the middle of a word
    @(negedge clk_i);
    push_words[0] = 32'h4B4A4948;
    push_words[1] = 32'h5B5A5958;
    push_words[2] = 32'h6B6A6968;
    push_n        = 3;
    @(negedge clk_i);
    push_n = 0;
    repeat (3) @(negedge clk_i);
    chk("arst_mid_word_data", mon_data[1], 32'h49);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(mon_valid), 32'd0);
    chk("arst_last", 32'(mon_last), 32'd0);
    chk("arst_rdena", 32'(mon_rdena), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    for (int n = 0; n < 20 && !mon_valid[1]; n++) begin
      @(negedge clk_i);
      #1;
    end
    chk("arst_restart_data", mon_data[1], 32'h68);
    chk("arst_restart_last", 32'(mon_last[1]), 32'd0);
    wait_idle(200);

    // Randomized traffic with backpressure and occasional flush
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      m_ready = ($urandom_range(0, 3) != 0);
      clr_i   = ($urandom_range(0, 99) == 0);
      if (clr_i) m_ready = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        push_words[0] = $urandom();
        push_n = 1;
      end else begin
        push_n = 0;
      end
    end
    @(negedge clk_i);
    clr_i   = 1'b0;
    push_n  = 0;
    m_ready = 1'b1;
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rl_fifo_reader.md
# rl_fifo_reader

Read-side drain engine for `rl_scfifo`. It issues `rdena` to the FIFO, absorbs the FIFO's read latency in a 2-entry word buffer, and presents the data as a valid/ready stream. Each DATA_SIZE word can optionally be split into narrower OUT_SIZE beats. The block sits between any `rl_scfifo` instance and a streaming consumer (serializer, bus master, transmitter), and sustains one beat per cycle.

## Interface
Parameters:
- `DATA_SIZE`, 32: FIFO word width.
- `OUT_SIZE`, 32: stream beat width. `DATA_SIZE/OUT_SIZE` must be a power of 2, ≥1, with no remainder; otherwise elaboration fails with `$error`.
- `FIFO_LATENCY`, 1: 0 means show-ahead FIFO (`REGISTERED_OUTPUT="NO"`); 1 means registered FIFO (`q_i` is valid the cycle after `rdena_o`). Other values are an elaboration error.
- `LSB_FIRST`, "YES": "YES" emits bits `[OUT_SIZE-1:0]` of a word first; "NO" emits the MSB slice first.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active low.
- `clr_i`  in  1  synchronous flush.
- `empty_i`  in  1  FIFO empty flag.
- `q_i`  in  DATA_SIZE  FIFO read data.
- `rdena_o`  out  1  FIFO read enable.
- `m_valid_o`  out  1  beat valid.
- `m_ready_i`  in  1  consumer accepts beat.
- `m_data_o`  out  OUT_SIZE  beat data.
- `m_last_o`  out  1  final beat of the current word.

## Operation
- RATIO = DATA_SIZE/OUT_SIZE. Beat counter width is clog2(RATIO), with a minimum of 1 bit.
- State:
  - word buffer: 2 entries, count 0..2;
  - `inflight` flag: a FIFO_LATENCY=1 read has been issued and its data is not yet captured;
  - beat counter `beat`.
- Beat pop: `m_valid_o & m_ready_i`.
- Word pop: a beat pop while `beat == RATIO-1`. It advances the buffer head and resets `beat` to 0. Any other beat pop increments `beat`.
- Issue rule: `rdena_o = rst_ni & ~clr_i & ~empty_i & (count + inflight - word_pop < 2)`. This is a combinational path from `m_ready_i` to `rdena_o`, and it is intentional because it gives full throughput.
- Capture, FIFO_LATENCY=0: `q_i` is written to the buffer tail on the same edge where `rdena_o` is high.
- Capture, FIFO_LATENCY=1: `inflight <= rdena_o`. When `inflight` is high, `q_i` is written to the buffer tail on that edge.
- Simultaneous capture and word pop: count is unchanged and the buffer stays ordered.
- The issue rule guarantees no overflow. Overflow is a bench assertion: count never exceeds 2.
- `m_valid_o = (count != 0)`.
- `m_data_o` is the head-word slice selected by `beat`, or by `RATIO-1-beat` when LSB_FIRST="NO".
- `m_last_o = m_valid_o & (beat == RATIO-1)`. With RATIO=1 it equals `m_valid_o`.
- Holding `m_ready_i` low freezes `m_data_o`, `m_last_o` and `beat`. The block never withdraws a valid beat.
- `clr_i` on an edge:
  - count, `inflight` and `beat` go to 0;
  - the buffer entries are not cleared;
  - a read in flight at that edge is discarded;
  - `rdena_o` is 0 during that cycle.
- Reset:
  - count=0, `inflight`=0, `beat`=0;
  - `m_valid_o`=0, `m_last_o`=0, `rdena_o`=0;
  - `m_data_o` is don't-care while invalid;
  - reset mid-word drops any partial word.

## Timing
- FIFO_LATENCY=1: `rdena_o` high in cycle c, `q_i` valid in c+1, `m_valid_o` high in c+2. First-beat latency from `empty_i` falling is 2 cycles.
- FIFO_LATENCY=0: `rdena_o` high in c, `m_valid_o` high in c+1. Latency is 1 cycle.
- Sustained throughput is 1 beat/cycle with `m_ready_i` held high, for both latencies and all RATIO values.
- With RATIO>1, `rdena_o` duty is at most 1/RATIO in steady state.
- All outputs except `rdena_o` are registered or decoded from registers.

## Structure
- Shared package `rl_fifo_pkg` holds:
  - functions `max()` and `is_power_of_2()`, shared with `rl_scfifo`;
  - localparam helpers for RATIO and beat-counter width.
- Sub-module `rl_fifo_reader_buf`: the 2-entry word queue, with ports push, pop, din, head, count.
- The top level holds the issue logic, the in-flight tracking and the beat unpacker.

## Test plan
- Back-to-back drain, FIFO_LATENCY=1, RATIO=1, `m_ready_i`=1. Preload 8 words 0x0..0x7. Expect `m_data_o` = 0..7 on 8 consecutive cycles starting 2 cycles after `empty_i` falls, and `rdena_o` high for 8 cycles.
- Unpack, DATA_SIZE=32, OUT_SIZE=8, LSB_FIRST="YES". Word 0x44332211 must give beats 11, 22, 33, 44, with `m_last_o` high only on 44. Repeat with LSB_FIRST="NO": beats 44, 33, 22, 11.
- Backpressure: toggle `m_ready_i` randomly, or hold it low for 5 cycles mid-word. Expect no beat lost or duplicated, `m_data_o` stable while stalled, and count never above 2.
- FIFO_LATENCY=0 against `rl_scfifo` REGISTERED_OUTPUT="NO" with 3 words. Expect `m_valid_o` one cycle after `empty_i` falls and `rdena_o` never high while `empty_i` is high.
- Flush: assert `clr_i` with one word in flight and one buffered. Expect the next cycle to show `m_valid_o`=0 and `beat`=0, and data from the discarded read never appears.
- Async reset mid-word: pull `rst_ni` low during beat 2 of 4. Expect all outputs at their reset values immediately, and a clean restart with beat 0 of the next word after release.
